axi_4_slave_mem_datapath: RTL and testbench

AXI_4_SLAVE_MEM_DATAPATH -- requirements
Module: axi_4_slave_mem_datapath

---
 rtl/axi_4_slave_mem_datapath_pkg.sv | 4 +
 rtl/axi_4_burst_addr_gen.sv | 32 +++
 rtl/axi_4_defs.svh | 23 ++
 rtl/axi_4_slave_mem_datapath.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_4_slave_mem_datapath.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_4_slave_mem_datapath_pkg.sv
// Package wrapper so the datapath files can import the shared AXI4 encodings.
package axi_4_slave_mem_datapath_pkg;
`include "axi_4_defs.svh"
endpackage

// File: rtl/axi_4_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts (reserved behaves as INCR).
module axi_4_burst_addr_gen
    import axi_4_slave_mem_datapath_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_wrap_mask;

    assign w_step      = ADDR_W'(1) << size;
    assign w_incr      = addr + w_step;
    // Wrap block is (len+1) beats of 2^size bytes, aligned to its own size.
    assign w_wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);

    always_comb begin
        next_addr = w_incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     next_addr = w_incr;
        endcase
    end

endmodule

// File: rtl/axi_4_defs.svh
// Shared encodings for the AXI4 slave memory datapath: FSM states, burst types, responses.
`ifndef AXI_4_DEFS_SVH
`define AXI_4_DEFS_SVH

typedef enum logic [2:0] {
    DP_IDLE,
    DP_RD_REQ,
    DP_RD_WAIT,
    DP_RD_HOLD,
    DP_WR_WAIT_CMD,
    DP_WR_REQ,
    DP_WR_WAIT,
    DP_WR_HOLD
} axi_4_dp_states_e;

localparam logic [1:0] BURST_FIXED = 2'b00;
localparam logic [1:0] BURST_INCR  = 2'b01;
localparam logic [1:0] BURST_WRAP  = 2'b10;

localparam logic [1:0] RESP_OKAY   = 2'b00;
localparam logic [1:0] RESP_SLVERR = 2'b10;

`endif

// File: rtl/axi_4_slave_mem_datapath.sv
// AXI4 slave datapath: sequences read/write burst beats onto a variable-latency memory
// port under beat-by-beat control from an external AXI channel controller.
module axi_4_slave_mem_datapath
    import axi_4_slave_mem_datapath_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m_arvalid,
    input  logic                s_arready,
    input  logic                m_awvalid,
    input  logic                s_awready,
    input  logic                m_wvalid,
    input  logic                s_wready,
    input  logic [ADDR_W-1:0]   m_araddr,
    input  logic [ADDR_W-1:0]   m_awaddr,
    input  logic [7:0]          m_arlen,
    input  logic [7:0]          m_awlen,
    input  logic [2:0]          m_arsize,
    input  logic [2:0]          m_awsize,
    input  logic [1:0]          m_arburst,
    input  logic [1:0]          m_awburst,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wlast,
    input  logic                m_rready,
    input  logic                s_rvalid,
    input  logic                incre_counter,
    input  logic                store_data,
    output logic                data_fetched,
    output logic                data_stored,
    output logic                s_rlast,
    output logic                wlast_done,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic [1:0]          s_bresp,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack
);

    axi_4_dp_states_e    r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len;
    logic [2:0]          r_size;
    logic [1:0]          r_burst;
    logic [7:0]          r_beat_cnt;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_wlast;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic [1:0]          r_bresp;

    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_last_beat;
    logic                w_ar_load, w_aw_load, w_advance;
    logic                w_rd_capture, w_rd_err, w_wr_latch, w_wr_err;
    logic                w_unused;

    // Write-channel handshakes are owned by the controller; store_data is the data-valid command.
    assign w_unused = &{1'b0, m_wvalid, s_wready};

    function automatic logic f_out_of_range(input logic [ADDR_W-1:0] a);
        return a >= ADDR_W'(MEM_BYTES);
    endfunction

    axi_4_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (w_next_addr)
    );

    assign w_last_beat = (r_beat_cnt == r_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= DP_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ar_load    = 1'b0;
        w_aw_load    = 1'b0;
        w_advance    = 1'b0;
        w_rd_capture = 1'b0;
        w_rd_err     = 1'b0;
        w_wr_latch   = 1'b0;
        w_wr_err     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        data_fetched = 1'b0;
        data_stored  = 1'b0;
        s_rlast      = 1'b0;
        wlast_done   = 1'b0;
        case (r_state)
            DP_IDLE: begin
                if (m_arvalid && s_arready) begin
                    w_ar_load   = 1'b1;
                    // Out-of-range beats skip the memory and land straight in HOLD.
                    w_rd_err    = f_out_of_range(m_araddr);
                    w_state_nxt = w_rd_err ? DP_RD_HOLD : DP_RD_REQ;
                end else if (m_awvalid && s_awready) begin
                    w_aw_load   = 1'b1;
                    w_state_nxt = DP_WR_WAIT_CMD;
                end
            end
            DP_RD_REQ: begin
                mem_req     = 1'b1;
                w_state_nxt = DP_RD_WAIT;
            end
            DP_RD_WAIT: begin
                if (mem_ack) begin
                    w_rd_capture = 1'b1;
                    w_state_nxt  = DP_RD_HOLD;
                end
            end
            DP_RD_HOLD: begin
                data_fetched = 1'b1;
                s_rlast      = w_last_beat;
                if (s_rvalid && m_rready && w_last_beat) begin
                    w_state_nxt = DP_IDLE;
                end else if (incre_counter && !w_last_beat) begin
                    w_advance   = 1'b1;
                    w_rd_err    = f_out_of_range(w_next_addr);
                    w_state_nxt = w_rd_err ? DP_RD_HOLD : DP_RD_REQ;
                end
            end
            DP_WR_WAIT_CMD: begin
                if (store_data) begin
                    w_wr_latch  = 1'b1;
                    w_wr_err    = f_out_of_range(r_addr);
                    w_state_nxt = w_wr_err ? DP_WR_HOLD : DP_WR_REQ;
                end
            end
            DP_WR_REQ: begin
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                w_state_nxt = DP_WR_WAIT;
            end
            DP_WR_WAIT: begin
                if (mem_ack) w_state_nxt = DP_WR_HOLD;
            end
            DP_WR_HOLD: begin
                data_stored = 1'b1;
                wlast_done  = r_wlast;
                if (incre_counter && !w_last_beat && !r_wlast) begin
                    w_advance   = 1'b1;
                    w_state_nxt = DP_WR_WAIT_CMD;
                end else if (r_wlast && !incre_counter && !store_data) begin
                    w_state_nxt = DP_IDLE;
                end
            end
            default: w_state_nxt = DP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wlast    <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_bresp    <= RESP_OKAY;
        end else begin
            if (w_ar_load) begin
                r_addr     <= m_araddr;
                r_len      <= m_arlen;
                r_size     <= m_arsize;
                r_burst    <= m_arburst;
                r_beat_cnt <= '0;
                r_rresp    <= RESP_OKAY;
            end else if (w_aw_load) begin
                r_addr     <= m_awaddr;
                r_len      <= m_awlen;
                r_size     <= m_awsize;
                r_burst    <= m_awburst;
                r_beat_cnt <= '0;
                r_bresp    <= RESP_OKAY;
            end
            if (w_advance) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_rd_capture) begin
                r_rdata <= mem_rdata;
                r_rresp <= RESP_OKAY;
            end
            if (w_rd_err) begin
                r_rdata <= '0;
                r_rresp <= RESP_SLVERR;
            end
            if (w_wr_latch) begin
                r_wdata <= m_wdata;
                r_wstrb <= m_wstrb;
                r_wlast <= m_wlast;
            end
            // Write error is sticky for the whole burst.
            if (w_wr_err) r_bresp <= RESP_SLVERR;
        end
    end

    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_bresp   = r_bresp;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_axi_4_slave_mem_datapath.sv
// Directed bench for axi_4_slave_mem_datapath: table of read bursts plus write, stall and reset sequences.
module tb_axi_4_slave_mem_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_arvalid, s_arready, m_awvalid, s_awready, m_wvalid, s_wready;
    logic [31:0] m_araddr, m_awaddr;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize;
    logic [1:0]  m_arburst, m_awburst;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_rready, s_rvalid, incre_counter, store_data;
    logic        data_fetched, data_stored, s_rlast, wlast_done;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_tests = 0;
    int n_fail  = 0;

    axi_4_slave_mem_datapath #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096)) dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .s_arready(s_arready), .m_awvalid(m_awvalid), .s_awready(s_awready),
        .m_wvalid(m_wvalid), .s_wready(s_wready),
        .m_araddr(m_araddr), .m_awaddr(m_awaddr), .m_arlen(m_arlen), .m_awlen(m_awlen),
        .m_arsize(m_arsize), .m_awsize(m_awsize), .m_arburst(m_arburst), .m_awburst(m_awburst),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_rready(m_rready), .s_rvalid(s_rvalid), .incre_counter(incre_counter), .store_data(store_data),
        .data_fetched(data_fetched), .data_stored(data_stored), .s_rlast(s_rlast), .wlast_done(wlast_done),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        int               lat;
        logic             oor;
        logic [3:0][31:0] exp_addr;
    } rd_vec_t;

    rd_vec_t vecs [6];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_read(input rd_vec_t v, input int idx);
        m_araddr = v.addr; m_arlen = v.len; m_arsize = v.size; m_arburst = v.burst;
        m_arvalid = 1'b1; s_arready = 1'b1;
        tick();
        m_arvalid = 1'b0; s_arready = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            if (v.oor) begin
                chk($sformatf("r%0d_b%0d_oor_noreq", idx, b), mem_req, 0);
                chk($sformatf("r%0d_b%0d_oor_fetched", idx, b), data_fetched, 1);
                chk($sformatf("r%0d_b%0d_oor_rdata", idx, b), s_rdata, 0);
                chk($sformatf("r%0d_b%0d_oor_rresp", idx, b), s_rresp, 2'b10);
            end else begin
                chk($sformatf("r%0d_b%0d_req", idx, b), mem_req, 1);
                chk($sformatf("r%0d_b%0d_we", idx, b), mem_we, 0);
                chk($sformatf("r%0d_b%0d_addr", idx, b), mem_addr, v.exp_addr[b]);
                tick();
                for (int i = 1; i < v.lat; i++) tick();
                mem_ack = 1'b1; mem_rdata = pat(v.exp_addr[b]);
                tick();
                mem_ack = 1'b0; mem_rdata = '0;
                chk($sformatf("r%0d_b%0d_fetched", idx, b), data_fetched, 1);
                chk($sformatf("r%0d_b%0d_rdata", idx, b), s_rdata, pat(v.exp_addr[b]));
                chk($sformatf("r%0d_b%0d_rresp", idx, b), s_rresp, 2'b00);
            end
            chk($sformatf("r%0d_b%0d_rlast", idx, b), s_rlast, (b == int'(v.len)));
            if (b < int'(v.len)) begin
                incre_counter = 1'b1;
                tick();
                incre_counter = 1'b0;
            end else begin
                s_rvalid = 1'b1; m_rready = 1'b1;
                tick();
                s_rvalid = 1'b0; m_rready = 1'b0;
                chk($sformatf("r%0d_done_idle", idx), data_fetched, 0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{32'h100, 8'd3, 3'd2, 2'b01, 2, 1'b0, {32'h10C, 32'h108, 32'h104, 32'h100}};
        vecs[1] = '{32'h038, 8'd3, 3'd2, 2'b10, 1, 1'b0, {32'h034, 32'h030, 32'h03C, 32'h038}};
        vecs[2] = '{32'h044, 8'd2, 3'd2, 2'b00, 3, 1'b0, {32'h0,   32'h044, 32'h044, 32'h044}};
        vecs[3] = '{32'h200, 8'd1, 3'd1, 2'b11, 1, 1'b0, {32'h0,   32'h0,   32'h202, 32'h200}};
        vecs[4] = '{32'h1000, 8'd0, 3'd2, 2'b01, 1, 1'b1, {32'h0,  32'h0,   32'h0,   32'h0}};
        vecs[5] = '{32'h007, 8'd1, 3'd0, 2'b01, 1, 1'b0, {32'h0,   32'h0,   32'h008, 32'h007}};

        reset = 1'b0;
        {m_arvalid, s_arready, m_awvalid, s_awready, m_wvalid, s_wready} = '0;
        m_araddr = '0; m_awaddr = '0; m_arlen = '0; m_awlen = '0;
        m_arsize = '0; m_awsize = '0; m_arburst = '0; m_awburst = '0;
        m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_rready = 1'b0; s_rvalid = 1'b0;
        incre_counter = 1'b0; store_data = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_fetched", data_fetched, 0);
        chk("rst_stored", data_stored, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_rresp", s_rresp, 0);
        chk("rst_bresp", s_bresp, 0);
        chk("rst_memaddr", mem_addr, 0);
        reset = 1'b1;
        tick();

        // Commands and memory acks while idle do nothing.
        incre_counter = 1'b1; store_data = 1'b1; mem_ack = 1'b1;
        tick();
        incre_counter = 1'b0; store_data = 1'b0; mem_ack = 1'b0;
        chk("idle_fetched", data_fetched, 0);
        chk("idle_stored", data_stored, 0);
        chk("idle_memreq", mem_req, 0);
        chk("idle_memaddr", mem_addr, 0);

        for (int r = 0; r < 6; r++) run_read(vecs[r], r);

        // FIXED write, two beats to 0x20 with partial strobes.
        m_awaddr = 32'h20; m_awlen = 8'd1; m_awsize = 3'd2; m_awburst = 2'b00;
        m_awvalid = 1'b1; s_awready = 1'b1;
        tick();
        m_awvalid = 1'b0; s_awready = 1'b0;
        chk("wr_cmd_stored", data_stored, 0);
        chk("wr_cmd_noreq", mem_req, 0);
        for (int b = 0; b < 2; b++) begin
            m_wdata = 32'hA000_0000 + b; m_wstrb = 4'b0011; m_wlast = (b == 1); store_data = 1'b1;
            tick();
            store_data = 1'b0; m_wlast = 1'b0; m_wdata = '0; m_wstrb = '0;
            chk($sformatf("wr_b%0d_req", b), mem_req, 1);
            chk($sformatf("wr_b%0d_we", b), mem_we, 1);
            chk($sformatf("wr_b%0d_addr", b), mem_addr, 32'h20);
            chk($sformatf("wr_b%0d_wdata", b), mem_wdata, 32'hA000_0000 + b);
            chk($sformatf("wr_b%0d_wstrb", b), mem_wstrb, 4'b0011);
            tick();
            chk($sformatf("wr_b%0d_wait_noreq", b), mem_req, 0);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            chk($sformatf("wr_b%0d_stored", b), data_stored, 1);
            chk($sformatf("wr_b%0d_wlast", b), wlast_done, (b == 1));
            if (b == 0) begin
                incre_counter = 1'b1;
                tick();
                incre_counter = 1'b0;
            end
        end
        chk("wr_bresp", s_bresp, 2'b00);
        tick();
        chk("wr_done_idle", data_stored, 0);
        chk("wr_done_bresp", s_bresp, 2'b00);

        // Out-of-range write beat: no memory access, SLVERR.
        m_awaddr = 32'h1000; m_awlen = 8'd0; m_awsize = 3'd2; m_awburst = 2'b01;
        m_awvalid = 1'b1; s_awready = 1'b1;
        tick();
        m_awvalid = 1'b0; s_awready = 1'b0;
        m_wdata = 32'h5555_5555; m_wstrb = 4'hF; m_wlast = 1'b1; store_data = 1'b1;
        tick();
        store_data = 1'b0; m_wlast = 1'b0;
        chk("wr_oor_noreq", mem_req, 0);
        chk("wr_oor_stored", data_stored, 1);
        chk("wr_oor_bresp", s_bresp, 2'b10);
        tick();
        chk("wr_oor_idle", data_stored, 0);

        // Read stalled by m_rready low; last-beat incre_counter must be ignored.
        m_araddr = 32'h300; m_arlen = 8'd0; m_arsize = 3'd2; m_arburst = 2'b01;
        m_arvalid = 1'b1; s_arready = 1'b1;
        tick();
        m_arvalid = 1'b0; s_arready = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = pat(32'h300);
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        s_rvalid = 1'b1; m_rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            incre_counter = (c == 1);
            tick();
            chk($sformatf("stall_c%0d_fetched", c), data_fetched, 1);
            chk($sformatf("stall_c%0d_rdata", c), s_rdata, pat(32'h300));
            chk($sformatf("stall_c%0d_noreq", c), mem_req, 0);
            chk($sformatf("stall_c%0d_addr", c), mem_addr, 32'h300);
        end
        incre_counter = 1'b0;
        m_rready = 1'b1;
        tick();
        s_rvalid = 1'b0; m_rready = 1'b0;
        chk("stall_done_idle", data_fetched, 0);

        // Reset asserted while waiting on a write ack.
        m_awaddr = 32'h40; m_awlen = 8'd0; m_awsize = 3'd2; m_awburst = 2'b01;
        m_awvalid = 1'b1; s_awready = 1'b1;
        tick();
        m_awvalid = 1'b0; s_awready = 1'b0;
        m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hC; m_wlast = 1'b1; store_data = 1'b1;
        tick();
        store_data = 1'b0; m_wlast = 1'b0;
        tick();
        chk("rstw_pre_addr", mem_addr, 32'h40);
        #2 reset = 1'b0;
        #1;
        chk("rstw_memreq", mem_req, 0);
        chk("rstw_memaddr", mem_addr, 0);
        chk("rstw_wdata", mem_wdata, 0);
        chk("rstw_wstrb", mem_wstrb, 0);
        chk("rstw_rdata", s_rdata, 0);
        chk("rstw_stored", data_stored, 0);
        mem_ack = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rstw_ack_stored", data_stored, 0);
        chk("rstw_ack_wlast", wlast_done, 0);
        chk("rstw_ack_memreq", mem_req, 0);
        chk("rstw_ack_bresp", s_bresp, 0);
        tick();
        chk("rstw_final_stored", data_stored, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
